// File: rtl/fetch_stage_pkg.sv
// Types shared by the fetch front end and the instruction queue.
// One queue entry carries a fetched word together with the PC it came from.
package rv32i_types;

   typedef enum logic [1:0] {
      REQ,
      WAIT,
      HOLD,
      DISCARD
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } iq_entry_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h1eceb000;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding imem read, results pushed into the
// instruction queue; stalls on a full queue, flushes and restarts on redirect.
module fetch_stage
   import rv32i_types::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [31:0]           imem_addr,
   output logic [3:0]            imem_rmask,
   input  logic [31:0]           imem_rdata,
   input  logic                  imem_resp,
   output logic [DATA_WIDTH-1:0] wdata_out,
   output logic                  enqueue_out,
   input  logic                  full_in,
   input  logic                  redirect_in,
   input  logic [31:0]           redirect_pc_in
);

   fetch_state_t state, state_next;
   logic [31:0]  pc, pc_next;
   iq_entry_t    hold_buf, hold_next;
   iq_entry_t    wdata;
   logic         enqueue;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= REQ;
         pc       <= RESET_PC;
         hold_buf <= '0;
      end else begin
         state    <= state_next;
         pc       <= pc_next;
         hold_buf <= hold_next;
      end
   end

   always_comb begin
      state_next = state;
      pc_next    = pc;
      hold_next  = hold_buf;
      enqueue    = 1'b0;
      wdata      = '0;
      unique case (state)
         REQ: state_next = WAIT;
         WAIT: begin
            if (imem_resp) begin
               wdata = '{pc: pc, inst: imem_rdata};
               if (!full_in) begin
                  enqueue    = 1'b1;
                  pc_next    = pc + 32'd4;
                  state_next = REQ;
               end else begin
                  hold_next  = '{pc: pc, inst: imem_rdata};
                  state_next = HOLD;
               end
            end
         end
         HOLD: begin
            wdata = hold_buf;
            if (!full_in) begin
               enqueue    = 1'b1;
               pc_next    = pc + 32'd4;
               state_next = REQ;
            end
         end
         DISCARD: if (imem_resp) state_next = REQ;
         default: state_next = REQ;
      endcase

      // A request issued in this REQ cycle is still in flight, so its
      // response must be swallowed in DISCARD before refetching.
      if (redirect_in) begin
         enqueue   = 1'b0;
         pc_next   = {redirect_pc_in[31:2], 2'b00};
         hold_next = '0;
         unique case (state)
            REQ:           state_next = DISCARD;
            WAIT, DISCARD: state_next = imem_resp ? REQ : DISCARD;
            default:       state_next = REQ;
         endcase
      end
   end

   // Outputs are quiet while rst is held so nothing leaks during reset.
   assign imem_addr   = pc;
   assign imem_rmask  = (state == REQ && !rst) ? 4'hf : 4'h0;
   assign enqueue_out = enqueue && !rst;
   assign wdata_out   = rst ? '0 : DATA_WIDTH'(wdata);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model, queue model and a scoreboard
// of expected queue entries in PC order.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic [63:0] wdata_out;
   logic        enqueue_out;
   logic        full_in;
   logic        redirect_in;
   logic [31:0] redirect_pc_in;

   logic        full_drv;
   logic        qmode;
   logic        deq;
   int          lat;
   int          fcnt;
   int          deq_cnt;
   int          n_checks;
   int          n_fail;
   logic [63:0] exp_q[$];
   logic [63:0] fifo[$];

   fetch_stage dut (
      .clk(clk), .rst(rst),
      .imem_addr(imem_addr), .imem_rmask(imem_rmask),
      .imem_rdata(imem_rdata), .imem_resp(imem_resp),
      .wdata_out(wdata_out), .enqueue_out(enqueue_out), .full_in(full_in),
      .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in)
   );

   always #5 clk = ~clk;

   assign full_in = qmode ? (fcnt >= 64) : full_drv;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h1eceb000: return 32'hcafebabe;
         32'h1eceb004: return 32'hecebcafe;
         32'h1eceb008: return 32'hbabebeef;
         32'h1eceb00c: return 32'hdeadbeef;
         default:      return a ^ 32'h5a5aa5a5;
      endcase
   endfunction

   function automatic logic [63:0] ent(input logic [31:0] a);
      return {a, mem_word(a)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input string tag, input logic [63:0] obs);
      if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
      else chk(tag, obs, exp_q.pop_front());
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_req(input string tag, input logic [31:0] a);
      chk({tag, "_rmask"}, 64'(imem_rmask), 64'hf);
      chk({tag, "_addr"}, 64'(imem_addr), 64'(a));
   endtask

   task automatic chk_reset();
      chk("rst_rmask", 64'(imem_rmask), 64'h0);
      chk("rst_addr", 64'(imem_addr), 64'h1eceb000);
      chk("rst_enq", 64'(enqueue_out), 64'h0);
      chk("rst_wdata", wdata_out, 64'h0);
   endtask

   // Memory: latch a request mid-cycle, answer lat cycles later.
   initial begin
      logic        pend;
      logic [31:0] paddr;
      int          cnt;
      pend = 1'b0; paddr = '0; cnt = 0;
      imem_resp = 1'b0; imem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst) pend = 1'b0;
         else if (imem_rmask == 4'hf) begin
            pend = 1'b1; paddr = imem_addr; cnt = lat;
         end
         @(posedge clk);
         #1;
         imem_resp = 1'b0;
         if (pend) begin
            cnt--;
            if (cnt <= 0) begin
               imem_resp  = 1'b1;
               imem_rdata = mem_word(paddr);
               pend       = 1'b0;
            end
         end
      end
   end

   // Enqueue monitor: direct scoreboard compare, or a 64-deep queue model
   // whose output is compared when dequeued.
   initial begin
      logic        do_push, do_pop, clr;
      logic [63:0] pd;
      fcnt = 0; deq_cnt = 0;
      forever begin
         @(negedge clk);
         do_push = 1'b0; do_pop = 1'b0; clr = 1'b0; pd = '0;
         if (rst) clr = 1'b1;
         else begin
            if (enqueue_out) begin
               chk("no_enq_when_full", 64'(full_in), 64'h0);
               if (qmode) begin do_push = 1'b1; pd = wdata_out; end
               else sb_check("enq_data", wdata_out);
            end
            if (qmode && deq && fifo.size() > 0) begin
               sb_check("deq_data", fifo[0]);
               do_pop = 1'b1;
               deq_cnt++;
            end
         end
         @(posedge clk);
         #1;
         if (clr) fifo.delete();
         else begin
            if (do_pop) void'(fifo.pop_front());
            if (do_push) fifo.push_back(pd);
         end
         fcnt = fifo.size();
      end
   end

   initial begin
      int base;
      n_checks = 0; n_fail = 0;
      rst = 1'b1; full_drv = 1'b0; qmode = 1'b0; deq = 1'b0; lat = 1;
      redirect_in = 1'b0; redirect_pc_in = '0;

      // reset, then three back-to-back fetches with 1-cycle memory
      cyc(); mid(); chk_reset();
      exp_q.push_back(ent(32'h1eceb000));
      exp_q.push_back(ent(32'h1eceb004));
      exp_q.push_back(ent(32'h1eceb008));
      cyc(); rst = 1'b0; mid(); chk_req("t1_req0", 32'h1eceb000);
      cyc(); mid(); chk("t1_enq0", 64'(enqueue_out), 64'h1);
      cyc(); mid(); chk_req("t1_req1", 32'h1eceb004);
      cyc(); mid(); chk("t1_enq1", 64'(enqueue_out), 64'h1);
      cyc(); mid(); chk_req("t1_req2", 32'h1eceb008);
      cyc(); mid(); chk("t1_enq2", 64'(enqueue_out), 64'h1);

      // mid-run reset, then backpressure on the second response
      cyc(); rst = 1'b1;
      cyc(); mid(); chk_reset();
      exp_q.push_back(ent(32'h1eceb000));
      exp_q.push_back(ent(32'h1eceb004));
      exp_q.push_back(ent(32'h1eceb008));
      cyc(); rst = 1'b0; mid(); chk_req("t2_req0", 32'h1eceb000);
      cyc(); mid(); chk("t2_enq0", 64'(enqueue_out), 64'h1);
      cyc(); mid(); chk_req("t2_req1", 32'h1eceb004);
      cyc(); full_drv = 1'b1; mid(); chk("t2_full_c1", 64'(enqueue_out), 64'h0);
      cyc(); mid(); chk("t2_full_c2", 64'(enqueue_out), 64'h0);
      chk("t2_hold_noreq", 64'(imem_rmask), 64'h0);
      cyc(); mid(); chk("t2_full_c3", 64'(enqueue_out), 64'h0);
      cyc(); full_drv = 1'b0; mid(); chk("t2_hold_enq", 64'(enqueue_out), 64'h1);
      chk("t2_hold_data", wdata_out, 64'h1eceb004_ecebcafe);
      cyc(); mid(); chk_req("t2_req2", 32'h1eceb008);
      cyc(); lat = 3; mid(); chk("t2_enq2", 64'(enqueue_out), 64'h1);

      // redirect while waiting on a slow response
      cyc(); mid(); chk_req("t3_req", 32'h1eceb00c);
      cyc(); redirect_in = 1'b1; redirect_pc_in = 32'h00001002;
      mid(); chk("t3_redir_enq", 64'(enqueue_out), 64'h0);
      cyc(); redirect_in = 1'b0; mid(); chk("t3_discard_noreq", 64'(imem_rmask), 64'h0);
      cyc(); lat = 1; mid(); chk("t3_late_resp", 64'(enqueue_out), 64'h0);
      exp_q.push_back(ent(32'h00001000));
      cyc(); mid(); chk_req("t3_newpc", 32'h00001000);
      cyc(); mid(); chk("t3_enq", 64'(enqueue_out), 64'h1);

      // redirect coinciding with a response
      cyc(); mid(); chk_req("t4_req", 32'h00001004);
      cyc(); redirect_in = 1'b1; redirect_pc_in = 32'h00002000;
      mid(); chk("t4_resp_redir", 64'(enqueue_out), 64'h0);
      exp_q.push_back(ent(32'h00002000));
      cyc(); redirect_in = 1'b0; mid(); chk_req("t4_newpc", 32'h00002000);
      cyc(); mid(); chk("t4_enq", 64'(enqueue_out), 64'h1);

      // redirect in HOLD while full drops
      cyc(); mid(); chk_req("t5_req", 32'h00002004);
      cyc(); full_drv = 1'b1; mid(); chk("t5_full", 64'(enqueue_out), 64'h0);
      cyc(); mid();
      cyc(); full_drv = 1'b0; redirect_in = 1'b1; redirect_pc_in = 32'h00003000;
      mid(); chk("t5_hold_redir", 64'(enqueue_out), 64'h0);
      exp_q.push_back(ent(32'h00003000));
      cyc(); redirect_in = 1'b0; mid(); chk_req("t5_newpc", 32'h00003000);
      cyc(); mid(); chk("t5_enq", 64'(enqueue_out), 64'h1);

      // redirect in REQ: old request issues, its response is discarded; PC wraps
      cyc(); redirect_in = 1'b1; redirect_pc_in = 32'hfffffffe;
      mid(); chk_req("t6_req_old", 32'h00003004);
      cyc(); redirect_in = 1'b0; mid(); chk("t6_discard", 64'(enqueue_out), 64'h0);
      exp_q.push_back(ent(32'hfffffffc));
      exp_q.push_back(ent(32'h00000000));
      cyc(); mid(); chk_req("t6_newpc", 32'hfffffffc);
      cyc(); mid(); chk("t6_enq", 64'(enqueue_out), 64'h1);
      cyc(); mid(); chk_req("t6_wrap", 32'h00000000);
      cyc(); mid(); chk("t6_wrap_enq", 64'(enqueue_out), 64'h1);
      chk("sb_drained", 64'(exp_q.size()), 64'h0);

      // fill a 64-deep queue, stall, drain in order
      cyc(); rst = 1'b1; qmode = 1'b1;
      cyc();
      cyc(); rst = 1'b0;
      for (int i = 0; i < 128; i++) exp_q.push_back(ent(32'h1eceb000 + 32'(4 * i)));
      for (int i = 0; i < 400 && fcnt < 64; i++) begin cyc(); mid(); end
      chk("t7_full", 64'(fcnt), 64'd64);
      for (int i = 0; i < 6; i++) begin
         cyc(); mid(); chk("t7_stall", 64'(enqueue_out), 64'h0);
      end
      base = deq_cnt;
      cyc(); deq = 1'b1;
      for (int i = 0; i < 400 && deq_cnt - base < 64; i++) mid();
      cyc(); deq = 1'b0;
      mid(); chk("t7_drained", 64'(deq_cnt - base), 64'd64);

      // reset mid-stream restarts at RESET_PC
      cyc(); rst = 1'b1;
      cyc(); mid(); chk_reset();
      exp_q.delete();
      for (int i = 0; i < 8; i++) exp_q.push_back(ent(32'h1eceb000 + 32'(4 * i)));
      base = deq_cnt;
      cyc(); rst = 1'b0; deq = 1'b1; mid(); chk_req("t8_restart", 32'h1eceb000);
      for (int i = 0; i < 100 && deq_cnt - base < 8; i++) mid();
      chk("t8_deq", 64'(deq_cnt - base >= 8), 64'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
